// File: rtl/reg_op_sequencer_pkg.sv
// Shared op codes, FSM state encodings and op helpers for the register op sequencer.
package reg_op_sequencer_pkg;

    typedef enum logic [2:0] {
        OP_CLR  = 3'd0,
        OP_LOAD = 3'd1,
        OP_INC  = 3'd2,
        OP_DEC  = 3'd3,
        OP_SHR  = 3'd4,
        OP_SHL  = 3'd5,
        OP_ROR  = 3'd6,
        OP_ROL  = 3'd7
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // CLR and LOAD are single-shot regardless of the requested repeat count.
    function automatic logic op_is_single(input op_e op);
        return (op == OP_CLR) || (op == OP_LOAD);
    endfunction

endpackage

// File: rtl/reg_seq_counter.sv
// Repeat-count down-counter: loads N on command accept, decrements once per RUN cycle.
module reg_seq_counter #(
    parameter int CNT_WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 load,
    input  logic [CNT_WIDTH-1:0] load_val,
    input  logic                 dec,
    output logic                 is_one
);

    logic [CNT_WIDTH-1:0] count;

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (dec) begin
            count <= count - 1'b1;
        end
    end

    assign is_one = (count == CNT_WIDTH'(1));

endmodule

// File: rtl/reg_op_sequencer.sv
// Command-driven controller that issues repeated one-hot control strobes to a datapath register.
module reg_op_sequencer
    import reg_op_sequencer_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int CNT_WIDTH  = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [2:0]            cmd_op,
    input  logic [CNT_WIDTH-1:0]  cmd_cnt,
    input  logic [DATA_WIDTH-1:0] cmd_data,
    input  logic                  cmd_fill,
    input  logic                  abort,
    input  logic [DATA_WIDTH-1:0] reg_out,
    output logic                  reg_cl,
    output logic                  reg_ld,
    output logic                  reg_inc,
    output logic                  reg_dec,
    output logic                  reg_sr,
    output logic                  reg_sl,
    output logic                  reg_ir,
    output logic                  reg_il,
    output logic [DATA_WIDTH-1:0] reg_in,
    output logic                  busy,
    output logic                  done
);

    state_e                state;
    op_e                   op_q;
    logic [DATA_WIDTH-1:0] data_q;
    logic                  fill_q;
    logic                  accept;
    logic                  cnt_is_one;
    logic                  run_active;
    logic [CNT_WIDTH-1:0]  n_val;
    logic                  unused_mid_bits;

    assign accept = cmd_valid && cmd_ready;
    assign n_val  = (op_is_single(op_e'(cmd_op)) || (cmd_cnt == '0)) ? CNT_WIDTH'(1) : cmd_cnt;

    reg_seq_counter #(.CNT_WIDTH(CNT_WIDTH)) u_counter (
        .clk      (clk),
        .rst      (rst),
        .load     (accept),
        .load_val (n_val),
        .dec      (state == ST_RUN),
        .is_one   (cnt_is_one)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            op_q      <= OP_CLR;
            data_q    <= '0;
            fill_q    <= 1'b0;
            cmd_ready <= 1'b1;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        op_q      <= op_e'(cmd_op);
                        data_q    <= cmd_data;
                        fill_q    <= cmd_fill;
                        state     <= ST_RUN;
                        cmd_ready <= 1'b0;
                        busy      <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (abort || cnt_is_one) begin
                        state <= ST_DONE;
                        done  <= 1'b1;
                    end
                end
                ST_DONE: begin
                    state     <= ST_IDLE;
                    done      <= 1'b0;
                    busy      <= 1'b0;
                    cmd_ready <= 1'b1;
                end
                default: begin
                    state     <= ST_IDLE;
                    done      <= 1'b0;
                    busy      <= 1'b0;
                    cmd_ready <= 1'b1;
                end
            endcase
        end
    end

    // Abort suppresses the strobe in the very cycle it is seen, so it gates the decode directly.
    assign run_active = (state == ST_RUN) && !abort;

    always_comb begin
        reg_cl  = 1'b0;
        reg_ld  = 1'b0;
        reg_inc = 1'b0;
        reg_dec = 1'b0;
        reg_sr  = 1'b0;
        reg_sl  = 1'b0;
        reg_ir  = 1'b0;
        reg_il  = 1'b0;
        reg_in  = '0;
        if (run_active) begin
            case (op_q)
                OP_CLR:  reg_cl  = 1'b1;
                OP_LOAD: begin
                    reg_ld = 1'b1;
                    reg_in = data_q;
                end
                OP_INC:  reg_inc = 1'b1;
                OP_DEC:  reg_dec = 1'b1;
                OP_SHR: begin
                    reg_sr = 1'b1;
                    reg_ir = fill_q;
                end
                OP_SHL: begin
                    reg_sl = 1'b1;
                    reg_il = fill_q;
                end
                OP_ROR: begin
                    reg_sr = 1'b1;
                    reg_ir = reg_out[0];
                end
                OP_ROL: begin
                    reg_sl = 1'b1;
                    reg_il = reg_out[DATA_WIDTH-1];
                end
                default: ;
            endcase
        end
    end

    // Only the end bits of reg_out feed the rotate path.
    assign unused_mid_bits = ^reg_out[DATA_WIDTH-2:1];

endmodule
